// File: rtl/inst_fetch_if.sv
// Instruction-memory read port: word-address request, single-cycle ack with data.
// master = fetch stage, slave = instruction memory.
interface inst_fetch_if #(
   parameter int ADDR_W = 14
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch.sv
// RV32I multi-cycle fetch stage: PC, imem handshake, branch/jump next-PC resolution.
// Optional retired-instruction counter is built only when IFETCH_RETIRE_CNT_EN is defined.
module inst_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          ADDR_W   = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   inst_fetch_if.master      imem,
   output logic [31:0]       inst,
   output logic [31:0]       pc,
   output logic [31:0]       link_addr,
   output logic              inst_valid,
   input  logic              exec_done,
   input  logic              Branch,
   input  logic [2:0]        BranchType,
   input  logic              Jump,
   input  logic [31:0]       rs1_data,
   input  logic [31:0]       rs2_data,
   input  logic [31:0]       imm,
   output logic              misalign_err,
   output logic [31:0]       retire_cnt
);
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic        taken;
   logic [31:0] next_pc;
   logic        retire;

   always_comb begin
      taken = 1'b0;
      case (BranchType)
         3'b000:  taken = (rs1_data == rs2_data);
         3'b001:  taken = (rs1_data != rs2_data);
         3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  taken = (rs1_data <  rs2_data);
         3'b111:  taken = (rs1_data >= rs2_data);
         default: taken = 1'b0;
      endcase
   end

   // Jump qualifies the opcode so a stray Jump on a non-jump opcode falls through.
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (Jump && inst_q[6:0] == OP_JALR)
         next_pc = (rs1_data + imm) & ~32'd1;
      else if (Jump && inst_q[6:0] == OP_JAL)
         next_pc = pc_q + imm;
      else if (Branch && taken)
         next_pc = pc_q + imm;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      retire  = 1'b0;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: if (imem.imem_ack) begin
                   inst_d  = imem.imem_rdata;
                   state_d = HOLD;
                end
         HOLD:  if (exec_done) begin
                   if (next_pc[1:0] != 2'b00) begin
                      err_d   = 1'b1;
                      state_d = HALT;
                   end else begin
                      pc_d    = next_pc;
                      retire  = 1'b1;
                      state_d = FETCH;
                   end
                end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= PC_RESET;
         inst_q  <= NOP;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end

`ifdef IFETCH_RETIRE_CNT_EN
   logic [31:0] retire_q, retire_d;
   assign retire_d = retire ? retire_q + 32'd1 : retire_q;
   always_ff @(posedge clk) begin
      if (!rst_n) retire_q <= '0;
      else        retire_q <= retire_d;
   end
   assign retire_cnt = retire_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign retire_cnt    = '0;
`endif

   assign imem.imem_req  = (state_q == FETCH);
   assign imem.imem_addr = pc_q[ADDR_W+1:2];
   assign inst_valid     = (state_q == HOLD);
   assign inst           = inst_q;
   assign pc             = pc_q;
   assign link_addr      = pc_q + 32'd4;
   assign misalign_err   = err_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, fetch handshake, branches, jumps, wrap, misalign, mid-fetch reset.
module tb_inst_fetch;
   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] BR   = 32'h0000_0063;
   localparam logic [31:0] JALR = 32'h0000_8067;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst, pc, link_addr, retire_cnt;
   logic        inst_valid, misalign_err;
   logic        exec_done, Branch, Jump;
   logic [2:0]  BranchType;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [31:0] exp_retire;
   int          vectors = 0;
   int          miscompares = 0;

   inst_fetch_if #(.ADDR_W(14)) imem_bus ();

   inst_fetch #(.PC_RESET(32'h0), .ADDR_W(14)) dut (
      .clk(clk), .rst_n(rst_n), .imem(imem_bus.master),
      .inst(inst), .pc(pc), .link_addr(link_addr), .inst_valid(inst_valid),
      .exec_done(exec_done), .Branch(Branch), .BranchType(BranchType), .Jump(Jump),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .misalign_err(misalign_err), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Retire the instruction held in HOLD, then fetch nxt with an immediate ack.
   task automatic retire(input logic [31:0] nxt, input logic br, input logic [2:0] bt,
                         input logic jp, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] exp_pc, input string tag);
      Branch = br; BranchType = bt; Jump = jp;
      rs1_data = r1; rs2_data = r2; imm = im;
      imem_bus.imem_rdata = nxt; imem_bus.imem_ack = 1'b1;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0; Branch = 1'b0; Jump = 1'b0;
      chk({tag, ".pc"},   pc, exp_pc);
      chk({tag, ".req"},  32'(imem_bus.imem_req), 32'd1);
      chk({tag, ".addr"}, 32'(imem_bus.imem_addr), {18'd0, exp_pc[15:2]});
      tick();
      chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
      chk({tag, ".inst"},  inst, nxt);
   endtask

   initial begin
      rst_n = 1'b0; exec_done = 1'b0; Branch = 1'b0; Jump = 1'b0; BranchType = 3'd0;
      rs1_data = '0; rs2_data = '0; imm = '0;
      imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = ADDI;
      tick(); tick();
      chk("rst.pc",     pc, 32'h0);
      chk("rst.inst",   inst, NOP);
      chk("rst.valid",  32'(inst_valid), 32'd0);
      chk("rst.req",    32'(imem_bus.imem_req), 32'd0);
      chk("rst.err",    32'(misalign_err), 32'd0);
      chk("rst.retire", retire_cnt, 32'd0);

      rst_n = 1'b1;
      tick();
      chk("boot.req",   32'(imem_bus.imem_req), 32'd1);
      chk("boot.valid", 32'(inst_valid), 32'd0);
      tick();
      chk("boot.valid1", 32'(inst_valid), 32'd1);
      chk("boot.inst",   inst, ADDI);
      chk("boot.pc",     pc, 32'h0);
      chk("boot.req0",   32'(imem_bus.imem_req), 32'd0);
      chk("boot.link",   link_addr, 32'h4);

      retire(JAL,  1'b0, 3'b000, 1'b0, 32'h0,          32'h0, 32'h0,          32'h04,       "fall");
      retire(BR,   1'b0, 3'b000, 1'b1, 32'h0,          32'h0, 32'h1C,         32'h20,       "jal");
      retire(JAL,  1'b1, 3'b000, 1'b0, 32'd7,          32'd7, 32'h10,         32'h30,       "beq");
      retire(BR,   1'b0, 3'b000, 1'b1, 32'h0,          32'h0, 32'hFFFF_FFF0,  32'h20,       "jalneg");
      retire(BR,   1'b1, 3'b001, 1'b0, 32'd7,          32'd7, 32'h10,         32'h24,       "bne");
      retire(BR,   1'b1, 3'b100, 1'b0, 32'hFFFF_FFFF,  32'd1, 32'h40,         32'h64,       "blt");
      retire(BR,   1'b1, 3'b110, 1'b0, 32'hFFFF_FFFF,  32'd1, 32'h40,         32'h68,       "bltu");
      retire(BR,   1'b1, 3'b101, 1'b0, 32'hFFFF_FFFF,  32'd1, 32'h40,         32'h6C,       "bge");
      retire(BR,   1'b1, 3'b111, 1'b0, 32'hFFFF_FFFF,  32'd1, 32'h08,         32'h74,       "bgeu");
      retire(JALR, 1'b1, 3'b010, 1'b0, 32'd7,          32'd7, 32'h10,         32'h78,       "b010");
      retire(ADDI, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFF0,  32'h0, 32'h0C,         32'hFFFF_FFFC, "jalrtop");
      chk("wrap.link", link_addr, 32'h0);
      retire(JALR, 1'b0, 3'b000, 1'b0, 32'h0,          32'h0, 32'h0,          32'h0,        "wrap");

      Jump = 1'b1; rs1_data = 32'h101; imm = 32'h2; exec_done = 1'b1;
      tick();
      chk("mis.err",   32'(misalign_err), 32'd1);
      chk("mis.req",   32'(imem_bus.imem_req), 32'd0);
      chk("mis.valid", 32'(inst_valid), 32'd0);
      chk("mis.pc",    pc, 32'h0);
      tick(); tick(); tick();
      chk("halt.err", 32'(misalign_err), 32'd1);
      chk("halt.req", 32'(imem_bus.imem_req), 32'd0);
      chk("halt.valid", 32'(inst_valid), 32'd0);
      exec_done = 1'b0; Jump = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("unhalt.err", 32'(misalign_err), 32'd0);

      imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = ADDI;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("wait.req",   32'(imem_bus.imem_req), 32'd1);
         chk("wait.addr",  32'(imem_bus.imem_addr), 32'd0);
         chk("wait.valid", 32'(inst_valid), 32'd0);
         tick();
      end
      imem_bus.imem_ack = 1'b1;
      tick();
      chk("wait.done", 32'(inst_valid), 32'd1);
      chk("wait.inst", inst, ADDI);

      imem_bus.imem_ack = 1'b0; exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      chk("mid.pc", pc, 32'h4);
      tick(); tick();
      chk("mid.addr", 32'(imem_bus.imem_addr), 32'd1);
      imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = JAL; rst_n = 1'b0;
      tick();
      chk("mid.pc0",   pc, 32'h0);
      chk("mid.inst",  inst, NOP);
      chk("mid.valid", 32'(inst_valid), 32'd0);
      chk("mid.req",   32'(imem_bus.imem_req), 32'd0);
      imem_bus.imem_ack = 1'b0; rst_n = 1'b1;
      tick();
      chk("late.inst",  inst, NOP);
      chk("late.valid", 32'(inst_valid), 32'd0);

      imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = ADDI;
      tick();
      for (int i = 1; i <= 10; i++)
         retire(ADDI, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'(i * 4), "run");
`ifdef IFETCH_RETIRE_CNT_EN
      exp_retire = 32'd10;
`else
      exp_retire = 32'd0;
`endif
      chk("run.retire", retire_cnt, exp_retire);
      chk("run.pc",     pc, 32'h28);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the multi-cycle RV32I core. Holds the PC, issues word reads to instruction memory through a req/ack handshake, presents the fetched word as `inst` to the decode/control logic, and computes the next PC after the downstream stage signals completion. Branch and jump resolution happens here, driven by the control outputs and the register-file operands.

## Interface
- `PC_RESET`, 32'h0000_0000, PC loaded on reset
- `ADDR_W`, 14, instruction-memory word-address width
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  ADDR_W  word address, equal to `pc[ADDR_W+1:2]`
- `imem_ack`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  instruction word
- `inst`  out  32  current instruction, stable while `inst_valid`
- `pc`  out  32  address of `inst`
- `link_addr`  out  32  `pc + 4`, for JAL/JALR write-back
- `inst_valid`  out  1  `inst` ready for decode/execute
- `exec_done`  in  1  downstream has finished with `inst`
- `Branch`  in  1  conditional-branch instruction
- `BranchType`  in  3  funct3 of the branch
- `Jump`  in  1  JAL or JALR
- `rs1_data`, `rs2_data`  in  32 each  register operands
- `imm`  in  32  sign-extended immediate for the current instruction
- `misalign_err`  out  1  sticky, fetch target not word-aligned
- `retire_cnt`  out  32  retired-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: `imem_req=0`. Always moves to FETCH on the next cycle.
- FETCH: `imem_req=1`, `imem_addr` held stable.
  - When `imem_ack=1` at an edge: `inst <= imem_rdata` and go to HOLD.
  - `imem_ack` is ignored in every state other than FETCH.
- HOLD: `inst_valid=1`.
  - When `exec_done=1` at an edge: `pc <= next_pc` and go to FETCH.
  - If `next_pc[1:0] != 0`, the PC is not updated; `misalign_err <= 1` and go to HALT.
- HALT: `imem_req=0`, `inst_valid=0`. Left only through reset.
- `next_pc` selection, evaluated in HOLD; JAL/JALR is decoded from `inst[6:0]`:
  - JAL: `pc + imm`
  - JALR: `(rs1_data + imm) & ~1`
  - `Branch` and taken: `pc + imm`
  - otherwise: `pc + 4`
- Branch is taken per `BranchType`:
  - 000: eq
  - 001: ne
  - 100: signed lt
  - 101: signed ge
  - 110: unsigned lt
  - 111: unsigned ge
  - 010 and 011: never taken
- All adds are 32-bit modulo. `pc = 0xFFFF_FFFC` with fall-through wraps to 0.
- `imem_addr` truncates the PC to ADDR_W bits. Upper PC bits are not checked.

## Timing
- Reset values: state IDLE, `pc=PC_RESET`, `inst=32'h0000_0013` (NOP), `inst_valid=0`, `imem_req=0`, `misalign_err=0`, `retire_cnt=0`.
- `rst_n` low at any edge, in any state, forces the reset values, including mid-FETCH. An `imem_ack` arriving in the same cycle is discarded.
- Minimum cycle sequence, with ack and done each arriving in the first cycle they are looked at:
  - first FETCH cycle is the cycle after reset release (IDLE lasts one cycle)
  - 1 FETCH cycle, then HOLD with `inst_valid` high
  - `pc` updates 1 cycle after `exec_done` is sampled
- Cost per instruction is 2 cycles + memory wait + execute wait.
- `exec_done` is sampled only in HOLD. `Branch`, `BranchType`, `Jump`, `rs1_data`, `rs2_data` and `imm` must be valid in the same cycle as `exec_done`.
- `inst` and `pc` change only on the FETCH→HOLD and HOLD→FETCH edges respectively.

## Configuration
- `IFETCH_RETIRE_CNT_EN` defined:
  - `retire_cnt` increments by 1 at every HOLD edge where `exec_done=1` and no misalignment occurs.
  - It wraps at 2^32.
- Not defined: `retire_cnt` is tied to 0 and the counter logic is not built.

## Test plan
- Reset, then `imem_ack` held high with `imem_rdata=0x00500093`:
  - `imem_req` rises 1 cycle after `rst_n` goes high.
  - `inst_valid` rises 1 cycle later, with `inst=0x00500093` and `pc=0`.
- BEQ with `rs1=rs2=7`, `imm=0x10`, `pc=0x20`, `exec_done` pulsed: next `pc=0x30`. Same stimulus with `BranchType=001`: next `pc=0x24`.
- BLTU vs BLT with `rs1=0xFFFF_FFFF`, `rs2=1`: BLT taken, BLTU not taken.
- JALR with `rs1=0x101`, `imm=2`: `pc=0x102` → misalign.
  - `misalign_err=1`, state HALT, `imem_req=0`.
  - Stays halted until `rst_n` is pulsed low.
- Memory wait and mid-FETCH reset:
  - `imem_ack` delayed 5 cycles: `imem_addr` stays stable and `inst_valid=0` throughout.
  - `rst_n` low in cycle 3 of the wait: `pc` returns to PC_RESET and the late ack is ignored.
- With `IFETCH_RETIRE_CNT_EN`, 10 fall-through instructions retired: `retire_cnt=10`, `pc=0x28`.
